// File: rtl/riscv_wb_stage.sv
// Write-back stage: accepts instructions from EX, collects one or two LSU read
// responses for loads, aligns/extends the data and pulses the register-file write port.
module riscv_wb_stage #(
    parameter bit DIFT_EN = 1'b1,
    parameter int TAG_W   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid_i,
    output logic             wb_ready_o,
    input  logic             regfile_we_i,
    input  logic [4:0]       regfile_waddr_i,
    input  logic             load_i,
    input  logic [1:0]       data_type_i,
    input  logic             data_sign_ext_i,
    input  logic [1:0]       data_reg_offset_i,
    input  logic             data_misaligned_i,
    input  logic             data_rvalid_i,
    input  logic [31:0]      data_rdata_i,
    input  logic [TAG_W-1:0] data_rdata_tag_i,
    output logic             regfile_we_o,
    output logic [4:0]       regfile_waddr_o,
    output logic [31:0]      regfile_wdata_o,
    output logic [TAG_W-1:0] regfile_wdata_tag_o,
    output logic             unexp_rvalid_o
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_FIRST = 2'd1;
    localparam logic [1:0] WAIT_LAST  = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic             we_reg;
    logic [4:0]       waddr_reg;
    logic [1:0]       type_reg;
    logic             sext_reg;
    logic [1:0]       offset_reg;
    logic             misaligned_reg;
    logic [31:0]      rdata1_reg;
    logic [TAG_W-1:0] tag1_reg;

    logic             transfer;
    logic             final_rsp;
    logic [7:0]       d_byte [4];
    logic [15:0]      half_raw;
    logic [7:0]       byte_raw;
    logic [31:0]      result_data;
    logic [TAG_W-1:0] result_tag;

    // Ready in WAIT_LAST only together with the final response, so a new
    // instruction can be taken in the very cycle the current load retires.
    assign wb_ready_o = (state_reg == IDLE) ||
                        ((state_reg == WAIT_LAST) && data_rvalid_i);
    assign transfer   = ex_valid_i && wb_ready_o;
    assign final_rsp  = (state_reg == WAIT_LAST) && data_rvalid_i;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign d_byte[gi] = data_rdata_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        half_raw = 16'h0000;
        case (offset_reg)
            2'd0:    half_raw = data_rdata_i[15:0];
            2'd1:    half_raw = data_rdata_i[23:8];
            2'd2:    half_raw = data_rdata_i[31:16];
            default: half_raw = {data_rdata_i[7:0], rdata1_reg[31:24]};
        endcase
    end

    assign byte_raw = d_byte[offset_reg];

    always_comb begin
        result_data = data_rdata_i;
        case (type_reg)
            2'b00: begin
                if (misaligned_reg) begin
                    case (offset_reg)
                        2'd1:    result_data = {data_rdata_i[7:0],  rdata1_reg[31:8]};
                        2'd2:    result_data = {data_rdata_i[15:0], rdata1_reg[31:16]};
                        2'd3:    result_data = {data_rdata_i[23:0], rdata1_reg[31:24]};
                        default: result_data = data_rdata_i;
                    endcase
                end
            end
            2'b01:   result_data = {{16{sext_reg & half_raw[15]}}, half_raw};
            default: result_data = {{24{sext_reg & byte_raw[7]}}, byte_raw};
        endcase
    end

    always_comb begin
        result_tag = misaligned_reg ? (data_rdata_tag_i | tag1_reg) : data_rdata_tag_i;
        if (!DIFT_EN) begin
            result_tag = '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (transfer && load_i) begin
                    state_next = data_misaligned_i ? WAIT_FIRST : WAIT_LAST;
                end
            end
            WAIT_FIRST: begin
                if (data_rvalid_i) begin
                    state_next = WAIT_LAST;
                end
            end
            WAIT_LAST: begin
                if (data_rvalid_i) begin
                    if (transfer && load_i) begin
                        state_next = data_misaligned_i ? WAIT_FIRST : WAIT_LAST;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            waddr_reg      <= 5'd0;
            type_reg       <= 2'b00;
            sext_reg       <= 1'b0;
            offset_reg     <= 2'd0;
            misaligned_reg <= 1'b0;
            rdata1_reg     <= 32'h0;
            tag1_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (transfer) begin
                we_reg         <= regfile_we_i;
                waddr_reg      <= regfile_waddr_i;
                type_reg       <= data_type_i;
                sext_reg       <= data_sign_ext_i;
                offset_reg     <= data_reg_offset_i;
                misaligned_reg <= data_misaligned_i;
            end
            if ((state_reg == WAIT_FIRST) && data_rvalid_i) begin
                rdata1_reg <= data_rdata_i;
                tag1_reg   <= data_rdata_tag_i;
            end
        end
    end

    // Address/data/tag only move on an actual write, so they hold the last written value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regfile_we_o        <= 1'b0;
            regfile_waddr_o     <= 5'd0;
            regfile_wdata_o     <= 32'h0;
            regfile_wdata_tag_o <= '0;
            unexp_rvalid_o      <= 1'b0;
        end else begin
            regfile_we_o <= final_rsp && we_reg;
            if (final_rsp && we_reg) begin
                regfile_waddr_o     <= waddr_reg;
                regfile_wdata_o     <= result_data;
                regfile_wdata_tag_o <= result_tag;
            end
            if ((state_reg == IDLE) && data_rvalid_i) begin
                unexp_rvalid_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_wb_stage.sv
// Randomized self-checking bench for riscv_wb_stage; a second instance with the
// tag datapath disabled runs on the same stimulus.
module tb_riscv_wb_stage;

    typedef struct {
        bit          load;
        bit          we;
        logic [4:0]  waddr;
        logic [1:0]  dtype;
        bit          sext;
        logic [1:0]  off;
        bit          mis;
        logic [31:0] r1;
        bit          t1;
        logic [31:0] r2;
        bit          t2;
        bit          b2b;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic        wb_ready_o;
    logic        regfile_we_i;
    logic [4:0]  regfile_waddr_i;
    logic        load_i;
    logic [1:0]  data_type_i;
    logic        data_sign_ext_i;
    logic [1:0]  data_reg_offset_i;
    logic        data_misaligned_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic [0:0]  data_rdata_tag_i;
    logic        regfile_we_o;
    logic [4:0]  regfile_waddr_o;
    logic [31:0] regfile_wdata_o;
    logic [0:0]  regfile_wdata_tag_o;
    logic        unexp_rvalid_o;

    logic        nd_ready;
    logic        nd_we;
    logic [4:0]  nd_waddr;
    logic [31:0] nd_wdata;
    logic [0:0]  nd_tag;
    logic        nd_unexp;

    int n_checks = 0;
    int n_pass   = 0;
    bit next_accepted = 1'b0;
    txn_t txq[$];

    always #5 clk = ~clk;

    riscv_wb_stage #(.DIFT_EN(1'b1), .TAG_W(1)) dut (
        .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .wb_ready_o(wb_ready_o),
        .regfile_we_i(regfile_we_i), .regfile_waddr_i(regfile_waddr_i), .load_i(load_i),
        .data_type_i(data_type_i), .data_sign_ext_i(data_sign_ext_i),
        .data_reg_offset_i(data_reg_offset_i), .data_misaligned_i(data_misaligned_i),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .data_rdata_tag_i(data_rdata_tag_i), .regfile_we_o(regfile_we_o),
        .regfile_waddr_o(regfile_waddr_o), .regfile_wdata_o(regfile_wdata_o),
        .regfile_wdata_tag_o(regfile_wdata_tag_o), .unexp_rvalid_o(unexp_rvalid_o)
    );

    riscv_wb_stage #(.DIFT_EN(1'b0), .TAG_W(1)) dut_nodift (
        .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .wb_ready_o(nd_ready),
        .regfile_we_i(regfile_we_i), .regfile_waddr_i(regfile_waddr_i), .load_i(load_i),
        .data_type_i(data_type_i), .data_sign_ext_i(data_sign_ext_i),
        .data_reg_offset_i(data_reg_offset_i), .data_misaligned_i(data_misaligned_i),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .data_rdata_tag_i(data_rdata_tag_i), .regfile_we_o(nd_we),
        .regfile_waddr_o(nd_waddr), .regfile_wdata_o(nd_wdata),
        .regfile_wdata_tag_o(nd_tag), .unexp_rvalid_o(nd_unexp)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: view the bytes as a little-endian window starting at the
    // load address, then extend the half/byte that sits at its bottom.
    function automatic logic [31:0] ref_data(input txn_t t);
        logic [63:0] win;
        logic [31:0] raw;
        win = t.mis ? {t.r2, t.r1} : {32'h0, t.r2};
        raw = win[31:0];
        if (t.mis) raw = 32'(win >> (8 * int'(t.off)));
        else       raw = t.r2 >> (8 * int'(t.off));
        case (t.dtype)
            2'b00:   return raw;
            2'b01:   return t.sext ? 32'($signed(raw[15:0])) : {16'h0, raw[15:0]};
            default: return t.sext ? 32'($signed(raw[7:0]))  : {24'h0, raw[7:0]};
        endcase
    endfunction

    function automatic txn_t mk(input bit load, input bit we, input logic [4:0] waddr,
                                input logic [1:0] dtype, input bit sext, input logic [1:0] off,
                                input bit mis, input logic [31:0] r1, input bit t1,
                                input logic [31:0] r2, input bit t2, input bit b2b);
        txn_t t;
        t.load = load; t.we = we; t.waddr = waddr; t.dtype = dtype; t.sext = sext;
        t.off = off; t.mis = mis; t.r1 = r1; t.t1 = t1; t.r2 = r2; t.t2 = t2; t.b2b = b2b;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input txn_t t);
        ex_valid_i        = 1'b1;
        regfile_we_i      = t.we;
        regfile_waddr_i   = t.waddr;
        load_i            = t.load;
        data_type_i       = t.dtype;
        data_sign_ext_i   = t.sext;
        data_reg_offset_i = t.off;
        data_misaligned_i = t.mis;
    endtask

    task automatic wait_cycles();
        int k;
        k = $urandom_range(0, 2);
        repeat (k) begin
            data_rvalid_i    = 1'b0;
            data_rdata_i     = $urandom;
            data_rdata_tag_i = 1'($urandom_range(0, 1));
            #1 check_eq("ready_waiting", 32'(wb_ready_o), 32'd0);
            step();
            check_eq("we_while_waiting", 32'(regfile_we_o), 32'd0);
        end
    endtask

    task automatic run_seq();
        txn_t t;
        bit was_acc;
        logic [31:0] exp_d;
        for (int i = 0; i < txq.size(); i++) begin
            t = txq[i];
            was_acc = next_accepted;
            next_accepted = 1'b0;
            if (!was_acc) begin
                drive_ex(t);
                #1 check_eq("ready_idle", 32'(wb_ready_o), 32'd1);
                step();
                ex_valid_i = 1'b0;
            end
            if (!t.load) begin
                if (was_acc) begin
                    #1 check_eq("ready_after_nonload", 32'(wb_ready_o), 32'd1);
                    step();
                end
                check_eq("we_nonload", 32'(regfile_we_o), 32'd0);
                continue;
            end
            if (!was_acc) check_eq("we_after_issue", 32'(regfile_we_o), 32'd0);
            wait_cycles();
            if (t.mis) begin
                data_rvalid_i = 1'b1; data_rdata_i = t.r1; data_rdata_tag_i = t.t1;
                #1 check_eq("ready_first_rsp", 32'(wb_ready_o), 32'd0);
                step();
                data_rvalid_i = 1'b0;
                check_eq("we_after_first", 32'(regfile_we_o), 32'd0);
                wait_cycles();
            end
            data_rvalid_i = 1'b1; data_rdata_i = t.r2; data_rdata_tag_i = t.t2;
            if (t.b2b && (i + 1 < txq.size())) begin
                drive_ex(txq[i+1]);
                next_accepted = 1'b1;
            end
            #1 check_eq("ready_last_rsp", 32'(wb_ready_o), 32'd1);
            step();
            data_rvalid_i = 1'b0;
            ex_valid_i    = 1'b0;
            exp_d = ref_data(t);
            check_eq("we_pulse", 32'(regfile_we_o), 32'(t.we));
            check_eq("we_pulse_nodift", 32'(nd_we), 32'(t.we));
            if (t.we) begin
                check_eq("waddr", 32'(regfile_waddr_o), 32'(t.waddr));
                check_eq("wdata", regfile_wdata_o, exp_d);
                check_eq("wtag", 32'(regfile_wdata_tag_o), 32'(t.mis ? (t.t1 | t.t2) : t.t2));
                check_eq("wdata_nodift", nd_wdata, exp_d);
            end
            check_eq("wtag_nodift", 32'(nd_tag), 32'd0);
            $display("txn %0d: type=%0d off=%0d mis=%0d we=%0d waddr=%0d wdata=0x%08h tag=%0d",
                     i, t.dtype, t.off, t.mis, t.we, regfile_waddr_o, regfile_wdata_o,
                     regfile_wdata_tag_o);
            if (!next_accepted) begin
                #1 check_eq("ready_back_idle", 32'(wb_ready_o), 32'd1);
                step();
                check_eq("we_single_cycle", 32'(regfile_we_o), 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ex_valid_i = 1'b0; regfile_we_i = 1'b0; regfile_waddr_i = 5'd0; load_i = 1'b0;
        data_type_i = 2'b00; data_sign_ext_i = 1'b0; data_reg_offset_i = 2'd0;
        data_misaligned_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        data_rdata_tag_i = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check_eq("rst_we", 32'(regfile_we_o), 32'd0);
        check_eq("rst_waddr", 32'(regfile_waddr_o), 32'd0);
        check_eq("rst_wdata", regfile_wdata_o, 32'd0);
        check_eq("rst_tag", 32'(regfile_wdata_tag_o), 32'd0);
        check_eq("rst_unexp", 32'(unexp_rvalid_o), 32'd0);
        check_eq("rst_ready", 32'(wb_ready_o), 32'd1);

        // Directed loads from the feature list, then a back-to-back chain.
        txq.push_back(mk(1, 1, 5'd5,  2'b00, 0, 2'd0, 0, 32'h0, 0, 32'hDEADBEEF, 1, 0));
        txq.push_back(mk(1, 1, 5'd6,  2'b10, 1, 2'd3, 0, 32'h0, 0, 32'h80FFFF7F, 0, 0));
        txq.push_back(mk(1, 1, 5'd7,  2'b10, 0, 2'd3, 0, 32'h0, 0, 32'h80FFFF7F, 0, 0));
        txq.push_back(mk(1, 1, 5'd8,  2'b01, 1, 2'd2, 0, 32'h0, 0, 32'h80010000, 0, 0));
        txq.push_back(mk(1, 1, 5'd9,  2'b00, 0, 2'd1, 1, 32'h44332211, 0, 32'h88776655, 1, 0));
        txq.push_back(mk(1, 1, 5'd10, 2'b01, 0, 2'd3, 1, 32'h44332211, 0, 32'h88776655, 1, 1));
        txq.push_back(mk(1, 1, 5'd11, 2'b00, 0, 2'd0, 0, 32'h0, 0, 32'h12345678, 1, 1));
        txq.push_back(mk(0, 1, 5'd12, 2'b00, 0, 2'd0, 0, 32'h0, 0, 32'h0, 0, 0));
        txq.push_back(mk(1, 0, 5'd13, 2'b00, 0, 2'd0, 0, 32'h0, 0, 32'hCAFEF00D, 1, 0));
        run_seq();
        check_eq("directed_last_waddr", 32'(regfile_waddr_o), 32'd11);

        txq.delete();
        for (int i = 0; i < 60; i++) begin
            txn_t t;
            t.dtype = 2'($urandom_range(0, 2));
            t.off   = 2'($urandom_range(0, 3));
            t.mis   = (t.dtype == 2'b00) ? (t.off != 2'd0) :
                      (t.dtype == 2'b01) ? (t.off == 2'd3) : 1'b0;
            t.load  = ($urandom_range(0, 9) != 0);
            t.we    = ($urandom_range(0, 5) != 0);
            t.waddr = 5'($urandom);
            t.sext  = 1'($urandom_range(0, 1));
            t.r1    = $urandom;
            t.t1    = 1'($urandom_range(0, 1));
            t.r2    = $urandom;
            t.t2    = 1'($urandom_range(0, 1));
            t.b2b   = 1'($urandom_range(0, 1));
            txq.push_back(t);
        end
        next_accepted = 1'b0;
        run_seq();
        check_eq("no_unexp_in_normal_flow", 32'(unexp_rvalid_o), 32'd0);

        // Reset while waiting for the first half of a misaligned load.
        txq.delete();
        drive_ex(mk(1, 1, 5'd20, 2'b00, 0, 2'd2, 1, 32'h0, 0, 32'h0, 0, 0));
        step();
        ex_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("midrst_we", 32'(regfile_we_o), 32'd0);
        check_eq("midrst_waddr", 32'(regfile_waddr_o), 32'd0);
        check_eq("midrst_wdata", regfile_wdata_o, 32'd0);
        check_eq("midrst_tag", 32'(regfile_wdata_tag_o), 32'd0);
        check_eq("midrst_ready", 32'(wb_ready_o), 32'd1);
        step();
        rst = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'hA5A5A5A5; data_rdata_tag_i = 1'b1;
        step();
        data_rvalid_i = 1'b0;
        check_eq("stray_rsp_no_write", 32'(regfile_we_o), 32'd0);
        check_eq("stray_rsp_unexp", 32'(unexp_rvalid_o), 32'd1);
        check_eq("stray_rsp_wdata", regfile_wdata_o, 32'd0);
        drive_ex(mk(0, 1, 5'd21, 2'b00, 0, 2'd0, 0, 32'h0, 0, 32'h0, 0, 0));
        step();
        ex_valid_i = 1'b0;
        check_eq("nonload_no_write", 32'(regfile_we_o), 32'd0);
        step();
        check_eq("nonload_no_write_later", 32'(regfile_we_o), 32'd0);
        check_eq("unexp_sticky", 32'(unexp_rvalid_o), 32'd1);
        check_eq("nodift_unexp_sticky", 32'(nd_unexp), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv_wb_stage.md
Name: riscv_wb_stage

Overview:
- Write-back stage and receiving end of the EX→WB valid/ready handshake: consumes `ex_valid_i` and drives `wb_ready_o` back to EX.
- Tracks the load in flight from EX, collects one or two LSU read responses, and aligns, merges and sign/zero-extends the data.
- Issues a single-cycle register-file write port pulse with the propagated DIFT tag.
- Non-load instructions pass through without a write.

Parameters:
- `DIFT_EN`, 1, 1 enables the tag datapath; 0 forces `regfile_wdata_tag_o` to 0.
- `TAG_W`, 1, width of the data tag carried with the load response.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous reset, active-high
- `ex_valid_i`  in  1  EX presents an instruction
- `wb_ready_o`  out  1  WB can accept the instruction this cycle
- `regfile_we_i`  in  1  instruction writes the register file through the load path
- `regfile_waddr_i`  in  5  destination register
- `load_i`  in  1  instruction is a load awaiting an LSU response
- `data_type_i`  in  2  00 word, 01 half, 10 byte
- `data_sign_ext_i`  in  1  sign-extend half/byte
- `data_reg_offset_i`  in  2  byte offset of the address
- `data_misaligned_i`  in  1  load needs two responses
- `data_rvalid_i`  in  1  LSU response valid
- `data_rdata_i`  in  32  LSU response data
- `data_rdata_tag_i`  in  TAG_W  LSU response tag
- `regfile_we_o`  out  1  write enable, registered
- `regfile_waddr_o`  out  5  write address, registered
- `regfile_wdata_o`  out  32  write data, registered
- `regfile_wdata_tag_o`  out  TAG_W  write tag, registered
- `unexp_rvalid_o`  out  1  sticky: response arrived with no load pending

Behaviour:
- Reset (async, `rst`=1):
  - State IDLE; all capture registers cleared.
  - `regfile_we_o`=0, `regfile_waddr_o`=0, `regfile_wdata_o`=0, `regfile_wdata_tag_o`=0, `unexp_rvalid_o`=0.
  - An in-flight load is dropped and produces no write.
- Handshake:
  - Transfer occurs when `ex_valid_i` & `wb_ready_o`.
  - `wb_ready_o`=1 in IDLE.
  - `wb_ready_o`=1 in WAIT_LAST when `data_rvalid_i`=1 (back-to-back acceptance).
  - `wb_ready_o`=0 otherwise.
  - `wb_ready_o` never depends on `ex_valid_i`.
- Capture on transfer: `regfile_we_i`, `regfile_waddr_i`, `data_type_i`, `data_sign_ext_i`, `data_reg_offset_i`, `data_misaligned_i`.
- FSM:
  - IDLE: on transfer with `load_i`=1, go to WAIT_FIRST if `data_misaligned_i`=1, else WAIT_LAST. A transfer with `load_i`=0 stays in IDLE and produces no write.
  - WAIT_FIRST: on `data_rvalid_i`, store `rdata1` and `tag1`, go to WAIT_LAST.
  - WAIT_LAST: on `data_rvalid_i`, form the result. Then go to IDLE, or re-enter WAIT_FIRST/WAIT_LAST if a new load transfers in the same cycle.
- Result formation (`d` = current rdata, `p` = stored `rdata1`, `o` = offset):
  - Aligned word: `d`.
  - In-word half: `d[8*o+:16]`, with `o` in {0,1,2}.
  - Byte: `d[8*o+:8]`.
  - Misaligned word, `o`=1/2/3: {`d[7:0]`,`p[31:8]`}, {`d[15:0]`,`p[31:16]`}, {`d[23:0]`,`p[31:24]`}.
  - Misaligned half, `o`=3: {`d[7:0]`,`p[31:24]`}.
  - Half/byte are sign-extended if `data_sign_ext_i`, else zero-extended.
- Tag: `d_tag` OR `tag1` (misaligned), else `d_tag`; masked to 0 when `DIFT_EN`=0.
- Write latency:
  - `regfile_we_o`=1 for exactly one cycle, the cycle after the final response, if the captured `regfile_we`=1.
  - `regfile_waddr_o`, `regfile_wdata_o` and `regfile_wdata_tag_o` are updated in the same cycle and hold afterwards.
- `data_rvalid_i` in IDLE: ignored for data and sets `unexp_rvalid_o`, which stays set until reset.
- A load captured with `regfile_we`=0 still consumes its responses but produces no write.

Test Plan:
- Aligned LW, `o`=0, rdata=0xDEADBEEF, tag=1, waddr=5 → one cycle after rvalid: `we`=1, waddr=5, wdata=0xDEADBEEF, tag=1; `wb_ready_o`=0 while waiting.
- LB sext, `o`=3, rdata=0x80FF_FF7F → wdata=0xFFFFFF80; LBU same → 0x00000080; LH sext `o`=2, rdata=0x8001_0000 → 0xFFFF8001.
- Misaligned LW `o`=1, r1=0x44332211 tag 0, r2=0x88776655 tag 1 → wdata=0x55443322, tag=1; misaligned LH `o`=3 → wdata=0x00005544 (zext).
- Back-to-back: final rvalid and new `ex_valid_i` in the same cycle → `wb_ready_o`=1, second load accepted, two `we` pulses with the correct waddr each.
- `rst` asserted while in WAIT_FIRST → outputs 0, later rvalid sets `unexp_rvalid_o`=1 with no write; a non-load transfer produces no write.
- `DIFT_EN`=0 with tag=1 responses → `regfile_wdata_tag_o`=0 throughout.
